modmul_issuer: RTL and testbench

Initiator-side sequencer for the modular multiplier. It accepts operand pairs on a valid/ready stream and drives one multiplier through its reset/enable/done handshake. It captures the remainder and presents it on a valid/ready result stream. It sits between the MSM bucket/point-arithmetic control logic and the multiplier instance, and adds a watchdog so a hung multiplier cannot stall the datapath silently.

---
 rtl/mod_pkg.sv | 18 +
 rtl/modmul_issuer_if.sv | 42 ++++
 rtl/modmul_watchdog.sv | 42 ++++
 rtl/modmul_issuer.sv | 118 +++++++++++
 tb/tb_modmul_issuer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared modulus parameters and issuer state type
// Shared by the issuer, the multiplier and the reduction blocks.
package mod_pkg;

  // Operand / remainder width.
  localparam int P_WIDTH = 16;

  // Modulus p (largest 16-bit prime).
  localparam logic [P_WIDTH-1:0] P_MOD = 16'd65521;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } issuer_state_e;

endpackage

// File: rtl/modmul_issuer_if.sv
// rtl/modmul_issuer_if.sv - operand, result and multiplier handshake bundle
// Ports (slave = issuer view):
//   in_valid/in_ready/in_a/in_b       operand stream into the issuer
//   out_valid/out_ready/out_r         result stream out of the issuer
//   mul_reset/mul_enable/mul_a/mul_b  issuer -> multiplier control and operands
//   mul_done/mul_r                    multiplier -> issuer completion and remainder
//   timeout_err                       sticky job-abandoned flag
interface modmul_issuer_if import mod_pkg::*; ();

  logic               in_valid;
  logic               in_ready;
  logic [P_WIDTH-1:0] in_a;
  logic [P_WIDTH-1:0] in_b;

  logic               out_valid;
  logic               out_ready;
  logic [P_WIDTH-1:0] out_r;

  logic               mul_reset;
  logic               mul_enable;
  logic [P_WIDTH-1:0] mul_a;
  logic [P_WIDTH-1:0] mul_b;
  logic               mul_done;
  logic [P_WIDTH-1:0] mul_r;

  logic               timeout_err;

  // Issuer side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_done, mul_r,
    output in_ready, out_valid, out_r, mul_reset, mul_enable, mul_a, mul_b,
           timeout_err
  );

  // Environment side: producer, consumer and multiplier.
  modport master (
    output in_valid, in_a, in_b, out_ready, mul_done, mul_r,
    input  in_ready, out_valid, out_r, mul_reset, mul_enable, mul_a, mul_b,
           timeout_err
  );

endinterface

// File: rtl/modmul_watchdog.sv
// rtl/modmul_watchdog.sv - cycle counter that flags a job running too long
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        hold the count at zero (asserted whenever not running)
//   count_en     advance the count by one per cycle
//   expired      count has reached TIMEOUT-1
module modmul_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT - 1));

  // Stops at TIMEOUT-1 so the count never wraps if the owner lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/modmul_issuer.sv
// rtl/modmul_issuer.sv - single-job sequencer driving one modular multiplier
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   bus          modmul_issuer_if.slave: operand stream in, result stream out,
//                multiplier reset/enable/done handshake, sticky timeout_err
module modmul_issuer import mod_pkg::*; #(
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  modmul_issuer_if.slave  bus
);

  issuer_state_e      state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               mul_reset_q, mul_reset_d;
  logic               mul_enable_q, mul_enable_d;
  logic               timeout_err_q, timeout_err_d;
  logic [P_WIDTH-1:0] out_r_q, out_r_d;
  logic [P_WIDTH-1:0] mul_a_q, mul_a_d;
  logic [P_WIDTH-1:0] mul_b_q, mul_b_d;

  logic wd_expired;

  // Counter is cleared everywhere but RUN, so it reads 0 on RUN entry.
  modmul_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q != RUN),
    .count_en (state_q == RUN),
    .expired  (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    out_r_d       = out_r_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        // in_ready_q gates acceptance so nothing is taken in the last
        // cycle of reset, when the state is already IDLE.
        if (in_ready_q && bus.in_valid) begin
          mul_a_d = bus.in_a;
          mul_b_d = bus.in_b;
          state_d = RST;
        end
      end
      RST: begin
        state_d = RUN;
      end
      RUN: begin
        // Done takes priority over a timeout in the same cycle.
        if (bus.mul_done) begin
          out_r_d = bus.mul_r;
          state_d = OUT;
        end else if (wd_expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered decodes of the next state, so they
    // change in the same cycle the state does and carry no input paths.
    in_ready_d   = (state_d == IDLE);
    mul_reset_d  = (state_d == RST);
    mul_enable_d = (state_d == RUN);
    out_valid_d  = (state_d == OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      mul_reset_q   <= 1'b0;
      mul_enable_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      out_r_q       <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      mul_reset_q   <= mul_reset_d;
      mul_enable_q  <= mul_enable_d;
      timeout_err_q <= timeout_err_d;
      out_r_q       <= out_r_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_r       = out_r_q;
  assign bus.mul_reset   = mul_reset_q;
  assign bus.mul_enable  = mul_enable_q;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_modmul_issuer.sv
// tb/tb_modmul_issuer.sv - directed vector bench for modmul_issuer
module tb_modmul_issuer;
  import mod_pkg::*;

  localparam int LAT = 5;

  typedef struct {
    logic [P_WIDTH-1:0] a;
    logic [P_WIDTH-1:0] b;
    logic [P_WIDTH-1:0] exp_r;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  modmul_issuer_if bus ();

  modmul_issuer #(
    .TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Multiplier model: done after LAT enabled cycles following its reset pulse.
  int unsigned lat_cnt = 0;
  logic        model_en = 1'b1;
  logic        force_done = 1'b0;
  logic [31:0] prod;

  always @(posedge clk) begin
    if (bus.mul_reset) lat_cnt <= 0;
    else if (bus.mul_enable && lat_cnt < LAT) lat_cnt <= lat_cnt + 1;
  end

  assign prod         = 32'(bus.mul_a) * 32'(bus.mul_b);
  assign bus.mul_r    = 16'(prod % 32'(P_MOD));
  assign bus.mul_done = (model_en && lat_cnt >= LAT) || force_done;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one job starting in the current cycle (cycle 0) and checks the
  // handshake timeline; returns in cycle 9 when out_ready is high, else cycle 8.
  task automatic run_job(input string tag, input logic [P_WIDTH-1:0] a,
                         input logic [P_WIDTH-1:0] b, input logic [P_WIDTH-1:0] exp_r);
    int cyc;
    check({tag, ".in_ready_c0"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = 16'hDEAD;
    bus.in_b     = 16'hBEEF;
    check({tag, ".rst_c1"}, 32'({bus.mul_reset, bus.mul_enable, bus.in_ready}), 32'b100);
    tick();
    check({tag, ".run_c2"}, 32'({bus.mul_reset, bus.mul_enable, bus.out_valid}), 32'b010);
    check({tag, ".mul_a"}, 32'(bus.mul_a), 32'(a));
    check({tag, ".mul_b"}, 32'(bus.mul_b), 32'(b));
    cyc = 2;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, ".out_valid_cycle"}, 32'(cyc), 8);
    check({tag, ".out_r"}, 32'(bus.out_r), 32'(exp_r));
    if (bus.out_ready) begin
      tick();
      check({tag, ".in_ready_c9"}, 32'({bus.in_ready, bus.out_valid}), 32'b10);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic bad;
    int   saw_valid;

    vecs[0] = '{a: 16'd3,     b: 16'd5,     exp_r: 16'd15};
    vecs[1] = '{a: 16'd1,     b: 16'd1,     exp_r: 16'd1};
    vecs[2] = '{a: 16'd65520, b: 16'd1,     exp_r: 16'd65520};
    vecs[3] = '{a: 16'd2,     b: 16'd3,     exp_r: 16'd6};
    vecs[4] = '{a: 16'd300,   b: 16'd300,   exp_r: 16'd24479};
    vecs[5] = '{a: 16'd65520, b: 16'd65520, exp_r: 16'd1};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    reset = 1'b1;
    repeat (3) tick();
    check("reset.flags", 32'({bus.in_ready, bus.out_valid, bus.mul_reset,
                              bus.mul_enable, bus.timeout_err}), 0);
    check("reset.data", 32'(bus.out_r | bus.mul_a | bus.mul_b), 0);
    reset = 1'b0;
    tick();
    check("reset.in_ready_rise", 32'(bus.in_ready), 1);

    // Single jobs from the vector table.
    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_r);
    end

    // Backpressure: result held for 10 cycles.
    bus.out_ready = 1'b0;
    run_job("bp", 16'd7, 16'd11, 16'd77);
    for (int i = 0; i < 10; i++) begin
      bad = !(bus.out_valid && bus.out_r == 16'd77 && !bus.in_ready);
      check($sformatf("bp.hold%0d", i), 32'(bad), 0);
      if (i < 9) tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp.release", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    // Timeout with a silent multiplier.
    model_en  = 1'b0;
    saw_valid = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'd9;
    bus.in_b     = 16'd9;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (bus.out_valid) saw_valid++;
      if (c < 9) tick();
    end
    check("to.c9_enable", 32'({bus.mul_enable, bus.timeout_err}), 32'b10);
    tick();
    check("to.c10", 32'({bus.timeout_err, bus.in_ready, bus.mul_enable, bus.out_valid}), 32'b1100);
    check("to.no_out_valid", 32'(saw_valid), 0);
    model_en = 1'b1;
    run_job("to.next", 16'd2, 16'd2, 16'd4);
    check("to.sticky", 32'(bus.timeout_err), 1);

    // Reset in cycle 3 of a job.
    bus.in_valid = 1'b1;
    bus.in_a     = 16'd100;
    bus.in_b     = 16'd200;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rr.flags", 32'({bus.in_ready, bus.out_valid, bus.mul_reset,
                           bus.mul_enable, bus.timeout_err}), 0);
    check("rr.data", 32'(bus.out_r | bus.mul_a | bus.mul_b), 0);
    reset = 1'b0;
    tick();
    check("rr.in_ready", 32'(bus.in_ready), 1);
    force_done = 1'b1;
    tick();
    tick();
    force_done = 1'b0;
    check("rr.late_done", 32'({bus.out_valid, bus.in_ready, bus.mul_enable}), 32'b010);
    run_job("rr.next", 16'd6, 16'd7, 16'd42);

    // Stale done pulsed in RST.
    bus.in_valid = 1'b1;
    bus.in_a     = 16'd12;
    bus.in_b     = 16'd12;
    tick();
    bus.in_valid = 1'b0;
    force_done   = 1'b1;
    tick();
    force_done = 1'b0;
    check("sd.rst_ignored", 32'({bus.out_valid, bus.mul_enable}), 32'b01);
    saw_valid = 2;
    while (!bus.out_valid && saw_valid < 40) begin
      tick();
      saw_valid++;
    end
    check("sd.cycle", 32'(saw_valid), 8);
    check("sd.out_r", 32'(bus.out_r), 144);
    tick();

    // Back-to-back jobs; each run_job begins in the cycle after acceptance.
    run_job("b2b0", vecs[1].a, vecs[1].b, vecs[1].exp_r);
    run_job("b2b1", vecs[2].a, vecs[2].b, vecs[2].exp_r);
    run_job("b2b2", vecs[3].a, vecs[3].b, vecs[3].exp_r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
